mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port data memory (6-bit address, 16-bit data, sync write, registered read) between
//  two requesters: port 0 = cpu, port 1 = loader/debug master (switch-driven memory load, hex dump).
//  Round-robin arbitration with req/gnt handshake, read-data return with valid strobe, and a lock so
//  one master can hold the memory across consecutive accesses (stack push/pop, read-modify-write).
//  Sits in top between cpu/loader and memory, on the same divided clock as both.
// PARAMETERS
//  ADDR_WIDTH    6   memory address width
//  DATA_WIDTH    16  memory data width
//  READ_LATENCY  1   cycles from mem_addr driven to mem_in valid; legal 1..3
// PORTS
//  clk          in   1           single clock (divided clock in top); all logic on rising edge
//  rst          in   1           synchronous, active-high reset
//  m0_req       in   1           port 0 request; hold with addr/we/data stable until m0_gnt
//  m0_we        in   1           port 0: 1 = write, 0 = read
//  m0_lock      in   1           port 0 keeps ownership for its next request
//  m0_addr      in   ADDR_WIDTH  port 0 address
//  m0_wdata     in   DATA_WIDTH  port 0 write data
//  m0_gnt       out  1           one-cycle pulse: port 0 access issued to memory this cycle
//  m0_rvalid    out  1           one-cycle pulse: m0_rdata valid
//  m0_rdata     out  DATA_WIDTH  port 0 read data
//  m1_*         --   --          identical set for port 1
//  mem_we       out  1           memory write enable
//  mem_addr     out  ADDR_WIDTH  memory address
//  mem_data     out  DATA_WIDTH  memory write data
//  mem_in       in   DATA_WIDTH  memory read data
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, owner=0, rr pointer "last"=1 (port 0 wins first tie), lock flag clear.
//  - States: IDLE -> ACCESS -> (write) IDLE | (read) WAIT -> IDLE. One transaction in flight at a time.
//  - IDLE: if any req, pick winner, capture its we/addr/wdata into regs, owner<=winner, go ACCESS.
//  - Pick: only one req -> it. Both -> lock flag set and owner requesting -> owner; else the port != last.
//    last<=winner at each pick. Requests arriving in ACCESS/WAIT wait; they are not lost.
//  - ACCESS (1 cycle): mem_addr/mem_data = captured regs, mem_we = captured we, owner gnt = 1.
//    Write -> IDLE next. Read -> WAIT, counter loaded with READ_LATENCY-1.
//  - WAIT: when counter==0, owner rvalid=1, owner rdata=mem_in (registered, held until next rvalid),
//    go IDLE; else decrement. READ_LATENCY=1: rvalid in the cycle after gnt.
//  - Latency: req seen at edge N -> gnt in cycle N+1; read rvalid in cycle N+1+READ_LATENCY.
//    Write throughput 1 per 2 cycles; read 1 per 2+READ_LATENCY cycles.
//  - Lock: flag <= owner's mX_lock sampled in ACCESS. Lock with no req from owner at next pick is
//    ignored (other port served); flag cleared whenever the other port wins.
//  - mem_we high only in ACCESS of a write; mem_addr/mem_data hold last captured values otherwise.
//  - gnt/rvalid never high on both ports in one cycle; rvalid only goes to the port that was granted.
//  - Requester changing inputs after capture but before gnt: ignored (captured copy used); spec
//    violation, bench flags it as warning.
//  - Reset mid-transaction: next edge returns to reset values; pending read dropped, no rvalid.
//  - mem_in outside WAIT completion is ignored.
// STRUCTURE
//  - Shared header mem_defs.vh: ADDR_WIDTH/DATA_WIDTH defaults, state encodings (IDLE/ACCESS/WAIT),
//    port index constants; also used by memory, cpu, loader.
//  - Sub-module rr_picker2: combinational 2-way pick from (req0, req1, last, lock, owner) -> winner, valid.
//  - FSM, capture regs, latency counter, rdata regs in mem_arbiter.
// TESTING
//  1 Port 0 writes 0xBEEF to addr 5 alone -> mem_we=1, mem_addr=5, mem_data=0xBEEF, m0_gnt in cycle after req.
//  2 Port 1 reads addr 5 (mem returns 0xBEEF), READ_LATENCY=1 and 3 -> m1_rvalid 1 and 3 cycles after
//    m1_gnt, m1_rdata=0xBEEF; m0_rvalid stays 0.
//  3 Both request continuously, no lock, 8 transactions -> grants alternate 0,1,0,1..., port 0 first.
//  4 Port 0 locked, both requesting, 3 writes addr 10..12 -> port 0 granted 3 in a row; lock dropped ->
//    port 1 granted next.
//  5 Reset asserted in WAIT of a read -> next cycle all outputs 0, no rvalid; after release port 0 wins tie.
//  6 Random 2000-cycle traffic vs. reference memory model -> all rdata match, never two gnt per cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared constants for the data-memory arbiter: default bus
//               widths, FSM state encodings, port indices and a helper that
//               turns a read latency into the wait-counter load value.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

   localparam int c_def_addr_width = 6;
   localparam int c_def_data_width = 16;

   typedef logic [1:0] state_t;

   localparam state_t c_st_idle   = 2'd0;
   localparam state_t c_st_access = 2'd1;
   localparam state_t c_st_wait   = 2'd2;

   localparam logic c_port_cpu    = 1'b0;
   localparam logic c_port_loader = 1'b1;

   // The wait counter counts down to zero, so it is loaded with latency-1.
   function automatic logic [1:0] lat_load(input int lat);
      return 2'(lat - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bus bundle between the two requesters, the arbiter and the
//               single-port data memory. The slave modport is the arbiter's
//               view; the master modport is the requester/memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = c_def_addr_width,
   parameter int DATA_WIDTH = c_def_data_width
);
   // port 0 (cpu)
   logic                  m0_req;
   logic                  m0_we;
   logic                  m0_lock;
   logic [ADDR_WIDTH-1:0] m0_addr;
   logic [DATA_WIDTH-1:0] m0_wdata;
   logic                  m0_gnt;
   logic                  m0_rvalid;
   logic [DATA_WIDTH-1:0] m0_rdata;
   // port 1 (loader / debug)
   logic                  m1_req;
   logic                  m1_we;
   logic                  m1_lock;
   logic [ADDR_WIDTH-1:0] m1_addr;
   logic [DATA_WIDTH-1:0] m1_wdata;
   logic                  m1_gnt;
   logic                  m1_rvalid;
   logic [DATA_WIDTH-1:0] m1_rdata;
   // memory side
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;
   logic [DATA_WIDTH-1:0] mem_in;

   modport slave (
      input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
      output m0_gnt, m0_rvalid, m0_rdata,
      input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output mem_we, mem_addr, mem_data,
      input  mem_in
   );

   modport master (
      output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
      input  m0_gnt, m0_rvalid, m0_rdata,
      output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  mem_we, mem_addr, mem_data,
      output mem_in
   );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_picker2.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_rr_picker2
// Description : Combinational two-way round-robin pick with ownership lock.
//               A lone requester always wins; on a tie the locked owner keeps
//               the memory, otherwise the port that did not win last time.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_rr_picker2
   import mem_arbiter_pkg::*;
(
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_last,
   input  logic i_lock,
   input  logic i_owner,
   output logic o_winner,
   output logic o_valid
);

   // Tie-break: lock holds the owner (who is requesting on a tie), else alternate.
   always_comb begin
      o_valid  = i_req0 | i_req1;
      o_winner = c_port_cpu;
      if (i_req0 && i_req1) begin
         o_winner = i_lock ? i_owner : ~i_last;
      end else if (i_req1) begin
         o_winner = c_port_loader;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares the single-port data memory between the cpu (port 0)
//               and the loader/debug master (port 1). One transaction in
//               flight: IDLE picks and captures, ACCESS drives the memory and
//               pulses gnt, WAIT counts out the read latency and returns data.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH   = c_def_addr_width,
   parameter int DATA_WIDTH   = c_def_data_width,
   parameter int READ_LATENCY = 1
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);

   localparam logic [1:0] c_lat_load = lat_load(READ_LATENCY);

   state_t                state_q,  state_d;
   logic                  owner_q,  owner_d;
   logic                  last_q,   last_d;
   logic                  lock_q,   lock_d;
   logic                  we_q,     we_d;
   logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
   logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
   logic [1:0]            cnt_q,    cnt_d;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
   logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

   logic pick_winner;
   logic pick_valid;
   logic rd_done;

   mem_arbiter_rr_picker2 u_picker (
      .i_req0   (bus.m0_req),
      .i_req1   (bus.m1_req),
      .i_last   (last_q),
      .i_lock   (lock_q),
      .i_owner  (owner_q),
      .o_winner (pick_winner),
      .o_valid  (pick_valid)
   );

   assign rd_done = (state_q == c_st_wait) && (cnt_q == 2'd0);

   // State and datapath registers; reset leaves port 0 to win the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= c_st_idle;
         owner_q  <= c_port_cpu;
         last_q   <= c_port_loader;
         lock_q   <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         cnt_q    <= 2'd0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         lock_q   <= lock_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   // Next state: pick and capture in IDLE, sample lock in ACCESS, count in WAIT.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      lock_d   = lock_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      case (state_q)
         c_st_idle: begin
            if (pick_valid) begin
               state_d = c_st_access;
               owner_d = pick_winner;
               last_d  = pick_winner;
               if (pick_winner != owner_q) begin
                  lock_d = 1'b0;
               end
               if (pick_winner == c_port_loader) begin
                  we_d    = bus.m1_we;
                  addr_d  = bus.m1_addr;
                  wdata_d = bus.m1_wdata;
               end else begin
                  we_d    = bus.m0_we;
                  addr_d  = bus.m0_addr;
                  wdata_d = bus.m0_wdata;
               end
            end
         end
         c_st_access: begin
            lock_d = (owner_q == c_port_loader) ? bus.m1_lock : bus.m0_lock;
            if (we_q) begin
               state_d = c_st_idle;
            end else begin
               state_d = c_st_wait;
               cnt_d   = c_lat_load;
            end
         end
         c_st_wait: begin
            if (cnt_q == 2'd0) begin
               state_d = c_st_idle;
               if (owner_q == c_port_loader) begin
                  rdata1_d = bus.mem_in;
               end else begin
                  rdata0_d = bus.mem_in;
               end
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: begin
            state_d = c_st_idle;
         end
      endcase
   end

   // Outputs: grant/write strobes from ACCESS, read return bypasses mem_in on its valid cycle.
   always_comb begin
      bus.m0_gnt    = (state_q == c_st_access) && (owner_q == c_port_cpu);
      bus.m1_gnt    = (state_q == c_st_access) && (owner_q == c_port_loader);
      bus.mem_we    = (state_q == c_st_access) && we_q;
      bus.mem_addr  = addr_q;
      bus.mem_data  = wdata_q;
      bus.m0_rvalid = rd_done && (owner_q == c_port_cpu);
      bus.m1_rvalid = rd_done && (owner_q == c_port_loader);
      bus.m0_rdata  = bus.m0_rvalid ? bus.mem_in : rdata0_q;
      bus.m1_rdata  = bus.m1_rvalid ? bus.mem_in : rdata1_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Two instances (read
//               latency 1 and 3) share the requester stimulus; `sel` chooses
//               which one is observed. Each instance has its own memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int AW = 6;
   localparam int DW = 16;

   typedef struct {
      int            port;
      int            cyc;
      logic [DW-1:0] data;
   } rd_exp_t;

   logic clk = 1'b0;
   logic rst;
   logic sel;
   always #5 clk = ~clk;

   logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;

   // requester-side arrays, copied onto the port signals by apply()
   logic          p_req[2], p_we[2], p_lock[2];
   logic [AW-1:0] p_addr[2];
   logic [DW-1:0] p_data[2];

   mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();
   mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if3 ();

   assign if1.m0_req = m0_req;  assign if1.m0_we = m0_we;  assign if1.m0_lock = m0_lock;
   assign if1.m0_addr = m0_addr; assign if1.m0_wdata = m0_wdata;
   assign if1.m1_req = m1_req;  assign if1.m1_we = m1_we;  assign if1.m1_lock = m1_lock;
   assign if1.m1_addr = m1_addr; assign if1.m1_wdata = m1_wdata;
   assign if3.m0_req = m0_req;  assign if3.m0_we = m0_we;  assign if3.m0_lock = m0_lock;
   assign if3.m0_addr = m0_addr; assign if3.m0_wdata = m0_wdata;
   assign if3.m1_req = m1_req;  assign if3.m1_we = m1_we;  assign if3.m1_lock = m1_lock;
   assign if3.m1_addr = m1_addr; assign if3.m1_wdata = m1_wdata;

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut1 (
      .clk (clk), .rst (rst), .bus (if1));
   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3)) dut3 (
      .clk (clk), .rst (rst), .bus (if3));

   // observed outputs of the selected instance
   logic          gnt0, gnt1, rv0, rv1, mwe;
   logic [AW-1:0] maddr;
   logic [DW-1:0] mdata, rd0, rd1;
   assign gnt0  = sel ? if3.m0_gnt    : if1.m0_gnt;
   assign gnt1  = sel ? if3.m1_gnt    : if1.m1_gnt;
   assign rv0   = sel ? if3.m0_rvalid : if1.m0_rvalid;
   assign rv1   = sel ? if3.m1_rvalid : if1.m1_rvalid;
   assign rd0   = sel ? if3.m0_rdata  : if1.m0_rdata;
   assign rd1   = sel ? if3.m1_rdata  : if1.m1_rdata;
   assign mwe   = sel ? if3.mem_we    : if1.mem_we;
   assign maddr = sel ? if3.mem_addr  : if1.mem_addr;
   assign mdata = sel ? if3.mem_data  : if1.mem_data;

   function automatic logic [DW-1:0] init_word(input int i);
      return 16'(i * 257) ^ 16'h5A5A;
   endfunction

   // memory models: synchronous write, read data appears READ_LATENCY cycles after the address
   logic [DW-1:0] mem1[64], mem3[64], pipe1[3], pipe3[3];
   assign if1.mem_in = pipe1[0];
   assign if3.mem_in = pipe3[2];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) mem1[i] <= init_word(i);
         for (int i = 0; i < 3; i++) pipe1[i] <= '0;
      end else begin
         if (if1.mem_we) mem1[if1.mem_addr] <= if1.mem_data;
         pipe1[0] <= mem1[if1.mem_addr];
         pipe1[1] <= pipe1[0];
         pipe1[2] <= pipe1[1];
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) mem3[i] <= init_word(i);
         for (int i = 0; i < 3; i++) pipe3[i] <= '0;
      end else begin
         if (if3.mem_we) mem3[if3.mem_addr] <= if3.mem_data;
         pipe3[0] <= mem3[if3.mem_addr];
         pipe3[1] <= pipe3[0];
         pipe3[2] <= pipe3[1];
      end
   end

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] ref_mem[64];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply();
      m0_req = p_req[0]; m0_we = p_we[0]; m0_lock = p_lock[0]; m0_addr = p_addr[0]; m0_wdata = p_data[0];
      m1_req = p_req[1]; m1_we = p_we[1]; m1_lock = p_lock[1]; m1_addr = p_addr[1]; m1_wdata = p_data[1];
   endtask

   task automatic set_port(input int p, input logic req, input logic we, input logic lock,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      p_req[p] = req; p_we[p] = we; p_lock[p] = lock; p_addr[p] = a; p_data[p] = d;
      apply();
   endtask

   task automatic do_reset(input logic s);
      sel = s;
      rst = 1'b1;
      set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
      set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(1'b0);
      checks++; if ({gnt0, gnt1} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", {gnt0, gnt1}); end
      checks++; if ({rv0, rv1} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", {rv0, rv1}); end
      checks++; if (mwe !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mwe); end
      checks++; if ({maddr, mdata} !== '0) begin errors++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", maddr, mdata); end
      checks++; if ({rd0, rd1} !== '0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", rd0, rd1); end
   endtask

   task automatic test_write_single();
      do_reset(1'b0);
      set_port(0, 1'b1, 1'b1, 1'b0, 6'd5, 16'hBEEF);
      tick();
      checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL wr_gnt: got %b want 10", {gnt0, gnt1}); end
      checks++; if (mwe !== 1'b1) begin errors++; $display("FAIL wr_mem_we: got %b want 1", mwe); end
      checks++; if (maddr !== 6'd5) begin errors++; $display("FAIL wr_mem_addr: got %0d want 5", maddr); end
      checks++; if (mdata !== 16'hBEEF) begin errors++; $display("FAIL wr_mem_data: got %h want beef", mdata); end
      set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
      tick();
      checks++; if ({gnt0, mwe} !== 2'b00) begin errors++; $display("FAIL wr_after: gnt0/mem_we got %b want 00", {gnt0, mwe}); end
      checks++; if (maddr !== 6'd5) begin errors++; $display("FAIL wr_addr_hold: got %0d want 5", maddr); end
   endtask

   task automatic test_read(input logic s);
      int lat;
      lat = s ? 3 : 1;
      do_reset(s);
      set_port(0, 1'b1, 1'b1, 1'b0, 6'd5, 16'hBEEF);
      tick();
      set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
      tick();
      set_port(1, 1'b1, 1'b0, 1'b0, 6'd5, '0);
      tick();
      checks++; if ({gnt0, gnt1} !== 2'b01) begin errors++; $display("FAIL rd%0d_gnt: got %b want 01", lat, {gnt0, gnt1}); end
      set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
      for (int k = 1; k <= lat; k++) begin
         tick();
         checks++; if (rv1 !== (k == lat)) begin errors++; $display("FAIL rd%0d_rvalid1 at +%0d: got %b want %b", lat, k, rv1, (k == lat)); end
         checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL rd%0d_rvalid0 at +%0d: got %b want 0", lat, k, rv0); end
         if (k == lat) begin
            checks++; if (rd1 !== 16'hBEEF) begin errors++; $display("FAIL rd%0d_rdata: got %h want beef", lat, rd1); end
         end
      end
      tick();
      checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL rd%0d_rvalid_end: got %b want 0", lat, rv1); end
      checks++; if (rd1 !== 16'hBEEF) begin errors++; $display("FAIL rd%0d_rdata_hold: got %h want beef", lat, rd1); end
   endtask

   task automatic test_round_robin();
      int n;
      int p;
      do_reset(1'b0);
      set_port(0, 1'b1, 1'b1, 1'b0, 6'd30, 16'h3000);
      set_port(1, 1'b1, 1'b1, 1'b0, 6'd40, 16'h4000);
      n = 0;
      for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
         tick();
         if (gnt0 && gnt1) begin
            checks++; errors++; $display("FAIL rr_double_gnt: both grants high at grant %0d", n);
         end else if (gnt0 || gnt1) begin
            p = gnt1 ? 1 : 0;
            checks++; if (p != n % 2) begin errors++; $display("FAIL rr_order: grant %0d went to port %0d want %0d", n, p, n % 2); end
            set_port(p, 1'b1, 1'b1, 1'b0, p_addr[p] + 6'd1, p_data[p] + 16'd1);
            n++;
         end
      end
      checks++; if (n != 8) begin errors++; $display("FAIL rr_timeout: got %0d grants want 8", n); end
      set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
      set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
      tick();
   endtask

   task automatic test_lock();
      int            exp_p[5] = '{0, 0, 0, 1, 0};
      int            exp_a[5] = '{10, 11, 12, 20, 13};
      int            n;
      int            n0;
      int            p;
      do_reset(1'b0);
      set_port(0, 1'b1, 1'b1, 1'b1, 6'd10, 16'h1000);
      set_port(1, 1'b1, 1'b1, 1'b0, 6'd20, 16'h2000);
      n = 0;
      n0 = 0;
      for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
         tick();
         if (gnt0 || gnt1) begin
            p = gnt1 ? 1 : 0;
            checks++; if (p != exp_p[n]) begin errors++; $display("FAIL lock_order: grant %0d went to port %0d want %0d", n, p, exp_p[n]); end
            checks++; if (int'(maddr) != exp_a[n]) begin errors++; $display("FAIL lock_addr: grant %0d addr %0d want %0d", n, maddr, exp_a[n]); end
            if (p == 0) begin
               n0++;
               case (n0)
                  1:       set_port(0, 1'b1, 1'b1, 1'b1, 6'd11, 16'h1001);
                  2:       set_port(0, 1'b1, 1'b1, 1'b1, 6'd12, 16'h1002);
                  3:       set_port(0, 1'b1, 1'b1, 1'b0, 6'd13, 16'h1003);
                  default: set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
               endcase
            end else begin
               set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
            end
            n++;
         end
      end
      checks++; if (n != 5) begin errors++; $display("FAIL lock_timeout: got %0d grants want 5", n); end
      set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
      set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
      tick();
   endtask

   task automatic test_reset_mid_read();
      logic saw_rv;
      do_reset(1'b1);
      set_port(1, 1'b1, 1'b0, 1'b0, 6'd7, '0);
      tick();
      checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL rst_read_gnt: got %b want 1", gnt1); end
      set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
      tick();
      rst = 1'b1;
      tick();
      checks++;
      if ({gnt0, gnt1, rv0, rv1, mwe, maddr, mdata, rd0, rd1} !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs: gnt=%b rv=%b we=%b addr=%h data=%h rd=%h/%h want all 0",
                  {gnt0, gnt1}, {rv0, rv1}, mwe, maddr, mdata, rd0, rd1);
      end
      rst = 1'b0;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      set_port(0, 1'b1, 1'b1, 1'b0, 6'd1, 16'h0101);
      set_port(1, 1'b1, 1'b1, 1'b0, 6'd2, 16'h0202);
      tick();
      checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL rst_tie_winner: got %b want 10", {gnt0, gnt1}); end
      saw_rv = rv0 | rv1;
      set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 5; i++) begin
         tick();
         saw_rv = saw_rv | rv0 | rv1;
         if (gnt1) set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
      end
      checks++; if (saw_rv !== 1'b0) begin errors++; $display("FAIL rst_dropped_read: rvalid seen %b want 0", saw_rv); end
   endtask

   task automatic new_req(input int p);
      p_req[p]  = 1'b1;
      p_we[p]   = 1'($urandom_range(0, 1));
      p_lock[p] = ($urandom_range(0, 9) < 3);
      p_addr[p] = 6'($urandom_range(0, 7));
      p_data[p] = 16'($urandom);
   endtask

   task automatic test_random(input logic s, input int ncyc);
      rd_exp_t q[$];
      rd_exp_t e;
      int      lat, c, free_at, w;
      logic    last_m, owner_m, flag_m, exp_any, exp_rv0, exp_rv1;
      logic    prev[2];
      lat = s ? 3 : 1;
      do_reset(s);
      c = 0; free_at = 0; last_m = 1'b1; owner_m = 1'b0; flag_m = 1'b0;
      for (int p = 0; p < 2; p++) if ($urandom_range(0, 1) == 1) new_req(p);
      apply();
      prev[0] = p_req[0];
      prev[1] = p_req[1];
      for (int i = 0; i < ncyc + 8; i++) begin
         tick();
         c++;
         exp_any = (c - 1 >= free_at) && (prev[0] || prev[1]);
         w = 0;
         if (exp_any) begin
            if (prev[0] && prev[1]) w = flag_m ? int'(owner_m) : int'(!last_m);
            else                    w = prev[1] ? 1 : 0;
         end
         checks++; if (gnt0 && gnt1) begin errors++; $display("FAIL rnd_double_gnt at cycle %0d", c); end
         checks++; if (gnt0 !== (exp_any && w == 0)) begin errors++; $display("FAIL rnd_gnt0 cycle %0d: got %b want %b", c, gnt0, (exp_any && w == 0)); end
         checks++; if (gnt1 !== (exp_any && w == 1)) begin errors++; $display("FAIL rnd_gnt1 cycle %0d: got %b want %b", c, gnt1, (exp_any && w == 1)); end
         if (exp_any) begin
            checks++; if (maddr !== p_addr[w]) begin errors++; $display("FAIL rnd_addr cycle %0d: got %0d want %0d", c, maddr, p_addr[w]); end
            checks++; if (mwe !== p_we[w]) begin errors++; $display("FAIL rnd_we cycle %0d: got %b want %b", c, mwe, p_we[w]); end
            if (p_we[w]) begin
               ref_mem[p_addr[w]] = p_data[w];
               free_at = c + 1;
            end else begin
               e.port = w; e.cyc = c + lat; e.data = ref_mem[p_addr[w]];
               q.push_back(e);
               free_at = c + 1 + lat;
            end
            owner_m = 1'(w);
            last_m  = 1'(w);
         end else begin
            checks++; if (mwe !== 1'b0) begin errors++; $display("FAIL rnd_idle_we cycle %0d: got %b want 0", c, mwe); end
         end
         exp_rv0 = (q.size() > 0) && (q[0].cyc == c) && (q[0].port == 0);
         exp_rv1 = (q.size() > 0) && (q[0].cyc == c) && (q[0].port == 1);
         checks++; if (rv0 !== exp_rv0) begin errors++; $display("FAIL rnd_rvalid0 cycle %0d: got %b want %b", c, rv0, exp_rv0); end
         checks++; if (rv1 !== exp_rv1) begin errors++; $display("FAIL rnd_rvalid1 cycle %0d: got %b want %b", c, rv1, exp_rv1); end
         if (exp_rv0 || exp_rv1) begin
            e = q.pop_front();
            checks++;
            if ((e.port == 0 ? rd0 : rd1) !== e.data) begin
               errors++;
               $display("FAIL rnd_rdata port %0d cycle %0d: got %h want %h", e.port, c, (e.port == 0 ? rd0 : rd1), e.data);
            end
         end
         if (exp_any) begin
            p_req[w] = 1'b0; p_lock[w] = 1'b0;
            if (i < ncyc && $urandom_range(0, 3) != 0) new_req(w);
         end
         for (int p = 0; p < 2; p++) begin
            if (!p_req[p] && i < ncyc && $urandom_range(0, 3) == 0) new_req(p);
         end
         apply();
         if (exp_any) flag_m = p_lock[w];
         prev[0] = p_req[0];
         prev[1] = p_req[1];
      end
      checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_missing_rvalid: %0d reads never returned", q.size()); end
   endtask

   initial begin
      sel = 1'b0;
      rst = 1'b1;
      set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
      set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
      test_reset();
      test_write_single();
      test_read(1'b0);
      test_read(1'b1);
      test_round_robin();
      test_lock();
      test_reset_mid_read();
      test_random(1'b0, 2000);
      test_random(1'b1, 1000);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
